// File: rtl/shift_amount_shifter.sv
// Iterative one-bit-per-clock shifter with a start/busy/done handshake.
// Operands are latched on acceptance; the result holds until the next accepted start.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; result holds the last completed value
// S_SHIFT | one shift step per edge until count reaches terminal value
// S_DONE  | single-cycle done pulse, then back to S_IDLE
module shift_amount_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] shamt_word,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW-1:0]   r_count;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_step;
  logic [SHW-1:0]   w_shamt;
  logic             w_pass_op;
  logic             w_unused_bits;

  assign w_shamt       = shamt_word[SHW-1:0];
  assign w_unused_bits = ^shamt_word[WIDTH-1:SHW];
  assign w_pass_op     = (op > 3'd4);

  // One-bit step on the latched operation.
  always_comb begin
    w_step = r_result;
    case (r_op)
      3'd0: w_step = {r_result[WIDTH-2:0], 1'b0};
      3'd1: w_step = {1'b0, r_result[WIDTH-1:1]};
      3'd2: w_step = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
      3'd3: w_step = {r_result[0], r_result[WIDTH-1:1]};
      3'd4: w_step = {r_result[WIDTH-2:0], r_result[WIDTH-1]};
      default: w_step = r_result;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((w_shamt == '0) || w_pass_op) w_state_nxt = S_DONE;
          else                              w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_count == SHW'(1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_count  <= '0;
      r_op     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_result <= data_in;
            r_count  <= w_shamt;
            r_op     <= op;
          end
        end
        S_SHIFT: begin
          r_result <= w_step;
          r_count  <= r_count - SHW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_amount_shifter.sv
// Self-checking bench for shift_amount_shifter: directed cases plus random
// operations compared against an arithmetic reference of the shift rules.
module tb_shift_amount_shifter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] shamt_word;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  int n_vec;
  int n_err;

  shift_amount_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .data_in   (data_in),
    .shamt_word(shamt_word),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] d, input int n);
    case (o)
      3'd0: return d << n;
      3'd1: return d >> n;
      3'd2: return 32'($signed(d) >>> n);
      3'd3: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      3'd4: return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
      default: return d;
    endcase
  endfunction

  function automatic int ref_busy_cycles(input logic [2:0] o, input int n);
    return (o > 3'd4 || n == 0) ? 1 : n + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    op         = 3'($urandom);
    data_in    = $urandom;
    shamt_word = $urandom;
  endtask

  // Launch one operation; with noisy=1 start stays high with changing operands
  // through SHIFT and DONE, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] d,
                        input logic [31:0] sw, input bit noisy);
    int n;
    int bc;
    bit got;
    logic [31:0] exp_r;
    n     = int'(sw[4:0]);
    exp_r = ref_shift(o, d, n);
    @(negedge clk);
    op = o; data_in = d; shamt_word = sw; start = 1'b1;
    @(posedge clk); #1;
    if (noisy) scramble_inputs();
    else begin
      start = 1'b0;
      scramble_inputs();
    end
    bc  = 0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busy) bc++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (noisy) scramble_inputs();
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " busy_cycles"}, 32'(bc), 32'(ref_busy_cycles(o, n)));
    chk({tag, " result"}, result, exp_r);
    @(posedge clk); #1;
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " result_hold"}, result, exp_r);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0; start = 1'b0; op = 3'd0; data_in = '0; shamt_word = '0;
    #12;
    chk("reset result", result, 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle no start busy", 32'(busy), 32'd0);

    run_op("T1 sll4",  3'd0, 32'h0000_0001, 32'h0000_0004, 1'b0);
    run_op("T2 sra31", 3'd2, 32'h8000_0000, 32'h0000_001F, 1'b0);
    run_op("T2 srl31", 3'd1, 32'h8000_0000, 32'h0000_001F, 1'b0);
    run_op("T3 sll0",  3'd0, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0);
    run_op("T4 ror1",  3'd3, 32'h0000_0001, 32'h0000_0001, 1'b0);
    run_op("T4 rol4",  3'd4, 32'h8000_0001, 32'h0000_0004, 1'b0);
    run_op("T4 pass",  3'd6, 32'hCAFE_F00D, 32'h0000_0013, 1'b0);
    run_op("T5 sll8",  3'd0, 32'h0000_0001, 32'h0000_0008, 1'b1);
    chk("T5 literal", result, 32'h0000_0100);

    // T6: reset three cycles into a 10-bit shift.
    @(negedge clk);
    op = 3'd0; data_in = 32'h0000_0003; shamt_word = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("T6 abort result", result, 32'h0);
    chk("T6 abort busy", 32'(busy), 32'd0);
    begin
      bit saw_done;
      saw_done = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done) saw_done = 1'b1;
      end
      chk("T6 no done", 32'(saw_done), 32'd0);
    end
    @(negedge clk); reset_n = 1'b1;
    run_op("T6 fresh", 3'd0, 32'h0000_0003, 32'd10, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] rd;
      logic [31:0] rs;
      ro = 3'($urandom);
      rd = $urandom;
      rs = $urandom;
      run_op($sformatf("rnd%0d", i), ro, rd, rs, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
